// File: rtl/seg_scan_mux_pkg.sv
// Shared display constants and helpers for the scan controller and the
// digit-to-segment decoder downstream of it.
package seg_scan_mux_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] CODE_DASH  = 4'd10;
  localparam logic [DIGIT_W-1:0] CODE_BLANK = 4'd15;

  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_ON   = 1'b1
  } slot_phase_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_mux_tick.sv
// Modulo-N counter: counts 0..N-1 and raises wrap while sitting at N-1,
// so the edge that returns it to zero is the edge that sees wrap high.
module tick_div #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  assign wrap = (cnt_reg == W'(N - 1));
  assign cnt  = cnt_reg;

  always_comb begin
    cnt_next = cnt_reg + W'(1);
    if (wrap) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scan controller: snapshots a BCD frame, walks the
// digits with an all-off dead band per slot, and applies blank/blink masks.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 2000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic [DIGIT_W-1:0]            digit_code,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          frame_done
);

  localparam int CW = idx_width(SCAN_DIV);
  localparam int BW = idx_width(BLINK_DIV);
  localparam int IW = idx_width(NUM_DIGITS);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYC);

  logic [CW-1:0]         cnt;
  logic                  slot_wrap;
  logic [BW-1:0]         blink_cnt_unused;
  logic                  blink_wrap;

  logic [IW-1:0]         idx_reg;
  logic [IW-1:0]         idx_next;
  logic [DIGIT_W-1:0]    frame_reg [NUM_DIGITS];
  logic                  snap_pending_reg;
  logic                  first_frame_reg;
  logic                  blink_phase_reg;

  logic                  frame_wrap;
  logic                  snap_load;
  slot_phase_e           phase;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic [NUM_DIGITS-1:0] suppress;
  logic [DIGIT_W-1:0]    cur_code;
  logic [NUM_DIGITS-1:0] sel_next;
  logic [DIGIT_W-1:0]    code_next;
  logic                  frame_done_next;

  tick_div #(
    .N (SCAN_DIV),
    .W (CW)
  ) u_slot_div (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (slot_wrap)
  );

  tick_div #(
    .N (BLINK_DIV),
    .W (BW)
  ) u_blink_div (
    .clk  (clk),
    .rst  (rst),
    .cnt  (blink_cnt_unused),
    .wrap (blink_wrap)
  );

  assign frame_wrap = slot_wrap && (idx_reg == LAST_IDX);
  // The first edge out of reset also snapshots, so frame 0 shows live data.
  assign snap_load  = snap_pending_reg || frame_wrap;

  always_comb begin
    idx_next = idx_reg;
    if (slot_wrap) begin
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IW'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign sel_onehot[gi] = (idx_reg == IW'(gi));
    assign suppress[gi]   = blank_mask[gi] | (blink_mask[gi] & blink_phase_reg);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        frame_reg[gi] <= CODE_BLANK;
      end else if (snap_load) begin
        frame_reg[gi] <= digits_in[gi*DIGIT_W +: DIGIT_W];
      end
    end
  end

  always_comb begin
    cur_code = CODE_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IW'(i)) begin
        cur_code = frame_reg[i];
      end
    end
  end

  // Outputs are decoded from the current counters and registered below,
  // so the display trails cnt/idx by exactly one cycle.
  always_comb begin
    phase           = (cnt < DEAD_LIM) ? PH_DEAD : PH_ON;
    sel_next        = '1;
    code_next       = CODE_BLANK;
    frame_done_next = (cnt == '0) && (idx_reg == '0) && !first_frame_reg;
    if ((phase == PH_ON) && ((sel_onehot & suppress) == '0)) begin
      sel_next  = ~sel_onehot;
      code_next = cur_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg          <= '0;
      snap_pending_reg <= 1'b1;
      first_frame_reg  <= 1'b1;
      blink_phase_reg  <= 1'b0;
      digit_sel        <= '1;
      digit_code       <= CODE_BLANK;
      frame_done       <= 1'b0;
    end else begin
      idx_reg          <= idx_next;
      snap_pending_reg <= 1'b0;
      if (frame_wrap) begin
        first_frame_reg <= 1'b0;
      end
      if (blink_wrap) begin
        blink_phase_reg <= ~blink_phase_reg;
      end
      digit_sel        <= sel_next;
      digit_code       <= code_next;
      frame_done       <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: vector table for the first frames, hand sequences
// for tearing/blink/dash/async reset, and a random run against a step model.
module tb_seg_scan_mux;

  localparam int ND = 6;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BD = 64;
  localparam int FR = ND * SD;
  localparam int NV = 50;

  typedef struct packed {
    logic [5:0] sel;
    logic [3:0] code;
    logic       fd;
  } out_t;

  typedef struct {
    int         step;
    logic [5:0] sel;
    logic [3:0] code;
    logic       fd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] digits_in;
  logic [5:0]  blank_mask;
  logic [5:0]  blink_mask;
  logic [3:0]  digit_code;
  logic [5:0]  digit_sel;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int last_en = -1;
  int gap = 0;

  int          mstep;
  int          vis_step;
  logic [23:0] mframe;
  out_t        exp_o;

  int   dig_tab [6] = '{1, 2, 3, 4, 5, 9};
  logic [5:0] sel_tab [6] = '{6'b111110, 6'b111101, 6'b111011,
                              6'b110111, 6'b101111, 6'b011111};
  vec_t vecs [NV];

  seg_scan_mux #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .DEAD_CYC   (DC),
    .BLINK_DIV  (BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .digit_code (digit_code),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Output expected for absolute step c since reset, derived arithmetically.
  function automatic out_t model_out(input int c, input logic [23:0] fr,
                                     input logic [5:0] bl, input logic [5:0] bk);
    out_t o;
    int   idx;
    logic hidden;
    idx    = (c / SD) % ND;
    hidden = ((bl >> idx) & 6'd1) != 6'd0 ||
             (((bk >> idx) & 6'd1) != 6'd0 && ((c / BD) % 2) == 1);
    o.sel  = 6'h3F;
    o.code = 4'hF;
    o.fd   = (c >= FR) && (c % FR == 0);
    if ((c % SD) >= DC && !hidden) begin
      o.sel  = ~(6'd1 << idx);
      o.code = 4'(fr >> (4 * idx));
    end
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mstep    <= 0;
      vis_step <= -1;
      mframe   <= 24'hFFFFFF;
      exp_o    <= {6'h3F, 4'hF, 1'b0};
    end else begin
      exp_o    <= model_out(mstep, mframe, blank_mask, blink_mask);
      vis_step <= mstep;
      mstep    <= mstep + 1;
      if (mstep == 0 || (mstep % FR) == FR - 1) begin
        mframe <= digits_in;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (step %0d, t=%0t)", nm, got, want, vis_step, $time);
    end
  endtask

  task automatic check_cycle();
    out_t got;
    int   lows;
    int   k;
    got = {digit_sel, digit_code, frame_done};
    n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL model step %0d: got sel=%b code=%0d fd=%b, want sel=%b code=%0d fd=%b",
               vis_step, got.sel, got.code, got.fd, exp_o.sel, exp_o.code, exp_o.fd);
    end
    if (rst) begin
      last_en = -1;
      gap     = 0;
    end else begin
      lows = $countones(~digit_sel);
      n_cmp++;
      if (lows > 1) begin
        n_bad++;
        $display("FAIL onehot: got %0d low bits (sel=%b), want at most 1", lows, digit_sel);
      end
      if (lows == 0) begin
        gap++;
      end else if (lows == 1) begin
        k = 0;
        for (int i = 0; i < ND; i++) begin
          if (((digit_sel >> i) & 6'd1) == 6'd0) k = i;
        end
        if (last_en >= 0 && k != last_en) begin
          n_cmp++;
          if (gap < DC) begin
            n_bad++;
            $display("FAIL deadband: got %0d idle cycles, want >= %0d", gap, DC);
          end
        end
        last_en = k;
        gap     = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic wait_vis_mod(input int m, input int r);
    int n;
    n = 0;
    while ((vis_step < 0 || (vis_step % m) != r) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_step: got step %0d want step mod %0d = %0d", vis_step, m, r);
    end
  endtask

  initial begin
    int c;
    int idx;
    int en0;
    int en2_ph0;
    int en2_ph1;
    int saw10;
    int saw13;

    digits_in  = {4'd9, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    blank_mask = '0;
    blink_mask = '0;

    for (int i = 0; i < NV; i++) begin
      vecs[i].step = i;
      vecs[i].fd   = (i == 24 || i == 48);
      if (i % SD == 0) begin
        vecs[i].sel  = 6'h3F;
        vecs[i].code = 4'hF;
      end else begin
        vecs[i].sel  = sel_tab[(i / SD) % ND];
        vecs[i].code = 4'(dig_tab[(i / SD) % ND]);
      end
    end

    repeat (3) tick();
    chk("rst_sel", 32'(digit_sel), 32'h3F);
    chk("rst_code", 32'(digit_code), 32'hF);
    chk("rst_fd", 32'(frame_done), 32'h0);

    #2 rst = 1'b0;
    for (int i = 0; i < NV; i++) begin
      tick();
      $display("vec %0d step %0d: sel=%b code=%0d fd=%b", i, vecs[i].step, digit_sel, digit_code, frame_done);
      chk("vec_sel", 32'(digit_sel), 32'(vecs[i].sel));
      chk("vec_code", 32'(digit_code), 32'(vecs[i].code));
      chk("vec_fd", 32'(frame_done), 32'(vecs[i].fd));
    end

    // Tearing: new data lands mid-slot of digit 3 and must wait a frame.
    wait_vis_mod(FR * 100, 2 * FR + 3 * SD + 2);
    digits_in = {6{4'd7}};
    $display("tearing: digits_in -> all 7 at step %0d", vis_step);
    while (vis_step < 4 * FR - 1) begin
      tick();
      c   = vis_step;
      idx = (c / SD) % ND;
      if (c % SD != 0) begin
        if (c < 3 * FR) chk("tear_hold", 32'(digit_code), 32'(dig_tab[idx]));
        else            chk("tear_new", 32'(digit_code), 32'd7);
      end
    end

    // Blank digit 0 always, blink digit 2.
    blank_mask = 6'b000001;
    blink_mask = 6'b000100;
    en0 = 0; en2_ph0 = 0; en2_ph1 = 0;
    repeat (3 * 2 * BD) begin
      tick();
      if (digit_sel[0] == 1'b0) en0++;
      if (digit_sel[2] == 1'b0) begin
        if (((vis_step / BD) % 2) == 0) en2_ph0++;
        else                            en2_ph1++;
      end
    end
    $display("blink: digit0 on %0d, digit2 on %0d visible / %0d hidden-phase", en0, en2_ph0, en2_ph1);
    chk("blank_d0", 32'(en0), 32'd0);
    chk("blink_hidden_d2", 32'(en2_ph1), 32'd0);
    chk("blink_visible_d2", 32'(en2_ph0 > 0), 32'd1);
    blank_mask = '0;
    blink_mask = '0;

    // Dash on digit 1, invalid code 13 on digit 4: both pass through.
    digits_in = {4'd0, 4'd13, 4'd0, 4'd0, 4'd10, 4'd0};
    saw10 = 0; saw13 = 0;
    repeat (3 * FR) begin
      tick();
      if (digit_sel == 6'b111101 && digit_code == 4'd10) saw10++;
      if (digit_sel == 6'b101111 && digit_code == 4'd13) saw13++;
    end
    $display("codes: dash seen %0d, code13 seen %0d", saw10, saw13);
    chk("dash_pass", 32'(saw10 > 0), 32'd1);
    chk("code13_pass", 32'(saw13 > 0), 32'd1);

    // Async reset in the middle of digit 4's ON window.
    wait_vis_mod(FR, 4 * SD + 2);
    chk("pre_rst_sel", 32'(digit_sel), 32'(6'b101111));
    chk("pre_rst_code", 32'(digit_code), 32'd13);
    #2 rst = 1'b1;
    #1;
    chk("async_sel", 32'(digit_sel), 32'h3F);
    chk("async_code", 32'(digit_code), 32'hF);
    digits_in = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd8};
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
    chk("restart_dead_sel", 32'(digit_sel), 32'h3F);
    tick();
    chk("restart_sel", 32'(digit_sel), 32'(6'b111110));
    chk("restart_code", 32'(digit_code), 32'd8);

    // Random run over 10 frames.
    for (int f = 0; f < 10; f++) begin
      for (int s = 0; s < FR; s++) begin
        if ($urandom_range(7) == 0)  digits_in  = 24'($urandom);
        if ($urandom_range(15) == 0) blank_mask = 6'($urandom & $urandom & $urandom);
        if ($urandom_range(15) == 0) blink_mask = 6'($urandom & $urandom);
        tick();
      end
      $display("random frame %0d: step %0d, %0d compared so far", f, vis_step, n_cmp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Time-multiplexed scan controller for the clock's multi-digit 7-segment display, directly upstream of the digit-to-segment decoder. It snapshots one BCD frame from the timekeeping core and walks the digits in turn. For each digit it presents one 4-bit code to the decoder and drives the matching active-low digit enable. It inserts an all-off dead band between digits (anti-ghosting) and supports per-digit blanking and blinking for time-set mode.

Parameters:
NUM_DIGITS, 6, number of digits scanned (HH MM SS).
SCAN_DIV, 50000, clock cycles per digit slot; must be >= 2.
DEAD_CYC, 2000, cycles at the start of each slot with all digits off; 1 <= DEAD_CYC < SCAN_DIV.
BLINK_DIV, 25000000, clock cycles per blink half-period; must be >= 2.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
digits_in  in  4*NUM_DIGITS  digit codes; digit k = bits [4k+3:4k]; 0-9 numeral, 10 dash, 11-15 blank
blank_mask  in  NUM_DIGITS  1 = force digit k blank
blink_mask  in  NUM_DIGITS  1 = digit k blinks
digit_code  out  4  code to decoder (registered)
digit_sel  out  NUM_DIGITS  active-low digit enables, one-hot-low or all-high (registered)
frame_done  out  1  one-cycle pulse at each frame wrap (registered)

Behaviour:
- Reset (async assert): cnt=0, idx=0, frame register = all 4'hF, blink_cnt=0, blink_phase=0, digit_sel=all 1s, digit_code=4'hF, frame_done=0, first_frame=1.
- Slot counter cnt runs 0..SCAN_DIV-1 and wraps. On wrap, idx increments 0..NUM_DIGITS-1, wrapping to 0.
- Snapshot: on any edge where the next state is (idx=0, cnt=0), the frame register loads digits_in. This includes the first edge after reset release. Changes to digits_in mid-frame are invisible until the next frame, so no tearing.
- Phases within a slot:
  - DEAD: cnt < DEAD_CYC. Drive digit_sel all 1s and digit_code 4'hF.
  - ON: cnt >= DEAD_CYC. Drive digit_sel[idx]=0 and all other bits 1. digit_code = frame[idx].
- Outputs are registered from the current (cnt, idx), so they lag the counters by one cycle. The ON window per slot is exactly SCAN_DIV-DEAD_CYC cycles.
- Suppression during ON: if blank_mask[idx]=1, or (blink_mask[idx]=1 and blink_phase=1), then digit_sel = all 1s and digit_code = 4'hF. blank_mask and blink_mask are sampled live every cycle, not snapshotted.
- Codes 10..15 pass through unmodified; the decoder owns their rendering.
- Blink: blink_cnt free-runs 0..BLINK_DIV-1. blink_phase toggles on each wrap. Phase 0 means visible.
- frame_done: high for exactly one cycle, aligned with the first DEAD output cycle of idx 0 of every frame except the first frame after reset (first_frame is cleared at the first wrap).
- Invariant: never more than one digit_sel bit low in any cycle. The all-high state separates any two different low bits by at least DEAD_CYC cycles.
- Reset mid-slot: outputs go to reset values immediately (asynchronously). Scanning restarts at idx 0 with a fresh snapshot on the first edge after release.
- Simultaneous blink toggle and slot change: both take effect on the same edge, with no priority interaction.

Decomposition:
- Shared display package holds CODE_DASH=4'd10 and CODE_BLANK=4'd15, used by this block and the decoder, plus a DIGIT_W=4 constant.
- One sub-module: tick_div (parameterised modulo-N counter with wrap pulse, async active-high reset). Instantiate it twice: once for the slot/cnt divider and once for the blink divider.

Test Plan:
- Reset/first frame (NUM_DIGITS=6, SCAN_DIV=4, DEAD_CYC=1, BLINK_DIV=64; digits_in = 6 digits 1,2,3,4,5,9 for idx 0..5): hold rst, then release.
  - Required: digit_sel=6'b111111 and digit_code=F during reset.
  - Then a repeating pattern of 1 dead cycle plus 3 ON cycles per digit: 111110/1, 111101/2, 111011/3, 110111/4, 101111/5, 011111/9.
  - No frame_done on the first frame; frame_done=1 on cycle 24 after release, then every 24 cycles.
- Tearing: change digits_in to all 7s at the midpoint of idx 3's slot. Required: digits 3-5 still show 4,5,9, and every digit shows 7 from the next frame.
- Blank and blink: blank_mask=6'b000001, blink_mask=6'b000100.
  - Required: digit 0 is never enabled.
  - Digit 2 is enabled only while blink_phase=0: 64 cycles visible, then 64 cycles suppressed, repeating.
- Dash and invalid codes: digit k=10 and digit m=13. Required: digit_code=10 and 13 appear unmodified during their ON windows.
- Async reset mid-ON at idx 4: assert rst between clock edges. Required: digit_sel goes all 1s within the same cycle, with no wait for a clock edge. After release, scanning restarts at idx 0 and loads a new snapshot.
- Invariant checker across a 10-frame random-stimulus run: digit_sel always has either zero or one bit low, and at least DEAD_CYC all-high cycles separate any two different enabled digits.
